// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MULT = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] w_hi, w_hi_n;
  logic [WIDTH-1:0] w_lo, w_lo_n;
  logic [WIDTH-1:0] opd, opd_n;

  logic             load;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] hi_n;
  logic             dbz_n;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] alu_res;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign busy   = (state == MUL) || (state == DIV);
  assign done   = (state == FIN);
  assign accept = start && !busy;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // Multiply: {w_hi,w_lo} shifts right; w_lo drains the multiplier.
  always_comb begin
    msum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opd} : '0);
    mul_hi = msum[WIDTH:1];
    mul_lo = {msum[0], w_lo[WIDTH-1:1]};
  end

  // Divide: w_hi is the partial remainder, w_lo fills with quotient.
  always_comb begin
    shifted = {w_hi, w_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opd};
    ge      = ~diff[WIDTH];
    div_hi  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    div_lo  = {w_lo[WIDTH-2:0], ge};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    w_hi_n  = w_hi;
    w_lo_n  = w_lo;
    opd_n   = opd;
    load    = 1'b0;
    res_n   = result;
    hi_n    = hi;
    dbz_n   = 1'b0;
    case (state)
      IDLE, FIN: begin
        if (accept) begin
          opd_n = b;
          cnt_n = '0;
          if (op == OP_MULT) begin
            w_hi_n  = '0;
            w_lo_n  = a;
            state_n = MUL;
          end else if (op == OP_DIV && b != '0) begin
            w_hi_n  = '0;
            w_lo_n  = a;
            state_n = DIV;
          end else if (op == OP_DIV) begin
            load    = 1'b1;
            res_n   = '1;
            hi_n    = a;
            dbz_n   = 1'b1;
            state_n = FIN;
          end else begin
            load    = 1'b1;
            res_n   = alu_res;
            hi_n    = '0;
            state_n = FIN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      MUL: begin
        w_hi_n = mul_hi;
        w_lo_n = mul_lo;
        cnt_n  = cnt + CW'(1);
        if (last) begin
          load    = 1'b1;
          res_n   = mul_lo;
          hi_n    = mul_hi;
          state_n = FIN;
        end
      end
      DIV: begin
        w_hi_n = div_hi;
        w_lo_n = div_lo;
        cnt_n  = cnt + CW'(1);
        if (last) begin
          load    = 1'b1;
          res_n   = div_lo;
          hi_n    = div_hi;
          state_n = FIN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      w_hi        <= '0;
      w_lo        <= '0;
      opd         <= '0;
      result      <= '0;
      hi          <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      w_hi  <= w_hi_n;
      w_lo  <= w_lo_n;
      opd   <= opd_n;
      if (load) begin
        result      <= res_n;
        hi          <= hi_n;
        zero        <= (res_n == '0);
        div_by_zero <= dbz_n;
      end
    end
  end

endmodule
